// File: rtl/cc_pkg.sv
// Shared types and constants for the serial sorting code calculator.
package cc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        OUT  = 2'd3
    } cc_state_e;

    typedef enum logic [1:0] {
        SUM   = 2'd0,
        RANGE = 2'd1,
        HALF  = 2'd2,
        MED   = 2'd3
    } cc_mode_e;

    localparam int OPT_SIGNED  = 0;
    localparam int OPT_DESC    = 1;
    localparam int OPT_MODE_LO = 2;
    localparam int OPT_MODE_HI = 3;

    // Wide enough that a full NUM-operand sum or a signed range cannot overflow.
    function automatic int cc_out_w(input int width, input int num);
        return width + $clog2(num) + 1;
    endfunction

endpackage

// File: rtl/cc_sort_insert.sv
// NUM-entry insertion sorter: each strobe places one operand into its sorted slot
// in a single cycle by comparing it against every filled entry in parallel.
module cc_sort_insert #(
    parameter int WIDTH = 4,
    parameter int NUM   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 insert,
    input  logic [WIDTH-1:0]     operand,
    input  logic                 is_signed,
    input  logic                 descending,
    input  logic                 clear,
    output logic [NUM*WIDTH-1:0] sorted
);

    logic [WIDTH-1:0] data_q [NUM];
    logic [WIDTH-1:0] prev   [NUM];
    logic [NUM-1:0]   filled_q;
    logic [NUM-1:0]   go;
    logic [NUM-1:0]   shift_in;

    // Strict ordering: an operand equal to a stored entry lands after it, keeping ties stable.
    function automatic logic precedes(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                      input logic sgn, input logic desc);
        logic lt;
        logic gt;
        lt = sgn ? ($signed(a) < $signed(b)) : (a < b);
        gt = sgn ? ($signed(a) > $signed(b)) : (a > b);
        return desc ? gt : lt;
    endfunction

    // go[] is monotonic over the filled prefix: the first set bit is the insertion slot.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        go       = '0;
        shift_in = '0;
        prev[0]  = operand;
        for (int i = 0; i < NUM; i++) begin
            go[i] = !filled_q[i] || precedes(operand, data_q[i], is_signed, descending);
        end
        for (int i = 1; i < NUM; i++) begin
            shift_in[i] = go[i-1];
            prev[i]     = data_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the array is small and its contents are visible, so it is reset like any
        // other register; sequential state always uses non-blocking assignments.
        if (!rst_n || clear) begin
            for (int i = 0; i < NUM; i++) begin
                data_q[i] <= '0;
            end
            filled_q <= '0;
        end else if (insert) begin
            for (int i = 0; i < NUM; i++) begin
                if (go[i]) begin
                    data_q[i] <= shift_in[i] ? prev[i] : operand;
                end
            end
            filled_q <= {filled_q[NUM-2:0], 1'b1};
        end
    end

    always_comb begin
        sorted = '0;
        for (int i = 0; i < NUM; i++) begin
            sorted[i*WIDTH +: WIDTH] = data_q[i];
        end
    end

endmodule

// File: rtl/cc_seq.sv
// Serial code calculator: loads NUM operands into an insertion sorter, then walks the
// sorted array for NUM cycles to reduce it to one result per transaction.
module cc_seq
    import cc_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NUM   = 4,
    parameter int OUT_W = cc_out_w(WIDTH, NUM)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_n,
    input  logic [3:0]       opt,
    output logic             in_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_n
);

    localparam int CW = $clog2(NUM + 1);
    localparam int KW = $clog2(NUM);

    cc_state_e              state_q, state_d;
    logic [CW-1:0]          cnt_q;
    logic [KW-1:0]          k_q;
    logic [3:0]             opt_q;
    logic [OUT_W-1:0]       acc_q, acc_d, base;
    logic [NUM*WIDTH-1:0]   sorted_flat;
    logic [WIDTH-1:0]       elem;
    logic [OUT_W-1:0]       elem_ext;
    logic                   accept, last_op, last_k;
    logic                   eff_signed, eff_desc;
    cc_mode_e               mode;

    assign in_ready = (state_q == IDLE) || (state_q == LOAD);
    assign accept   = in_valid && in_ready;
    assign last_op  = (cnt_q == CW'(NUM - 1));
    assign last_k   = (k_q == KW'(NUM - 1));
    assign mode     = cc_mode_e'(opt_q[OPT_MODE_HI:OPT_MODE_LO]);

    // The first operand is sorted in the same cycle its options are latched.
    assign eff_signed = (state_q == IDLE) ? opt[OPT_SIGNED] : opt_q[OPT_SIGNED];
    assign eff_desc   = (state_q == IDLE) ? opt[OPT_DESC]   : opt_q[OPT_DESC];

    cc_sort_insert #(
        .WIDTH (WIDTH),
        .NUM   (NUM)
    ) u_sort (
        .clk        (clk),
        .rst_n      (rst_n),
        .insert     (accept),
        .operand    (in_n),
        .is_signed  (eff_signed),
        .descending (eff_desc),
        .clear      (state_q == OUT),
        .sorted     (sorted_flat)
    );

    assign elem     = sorted_flat[int'(k_q)*WIDTH +: WIDTH];
    assign elem_ext = {{(OUT_W-WIDTH){opt_q[OPT_SIGNED] & elem[WIDTH-1]}}, elem};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = LOAD;
            LOAD:    if (accept && last_op) state_d = CALC;
            CALC:    if (last_k) state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Range subtracts the end that holds the minimum, so the result never goes negative.
    always_comb begin
        base  = (k_q == '0) ? '0 : acc_q;
        acc_d = acc_q;
        case (mode)
            SUM:   acc_d = base + elem_ext;
            HALF:  if (int'(k_q) < NUM/2) acc_d = base + elem_ext;
            RANGE: begin
                if (k_q == '0) begin
                    acc_d = opt_q[OPT_DESC] ? elem_ext : -elem_ext;
                end else if (last_k) begin
                    acc_d = acc_q + (opt_q[OPT_DESC] ? -elem_ext : elem_ext);
                end
            end
            MED:   if (int'(k_q) == NUM/2) acc_d = elem_ext;
            default: acc_d = acc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            k_q       <= '0;
            opt_q     <= '0;
            acc_q     <= '0;
            out_valid <= 1'b0;
            out_n     <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state_q)
                IDLE: if (accept) begin
                    opt_q <= opt;
                    cnt_q <= CW'(1);
                end
                LOAD: if (accept) cnt_q <= cnt_q + CW'(1);
                CALC: begin
                    acc_q <= acc_d;
                    k_q   <= last_k ? '0 : k_q + KW'(1);
                end
                OUT: begin
                    out_valid <= 1'b1;
                    out_n     <= acc_q;
                    cnt_q     <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cc_seq.sv
// Directed bench for cc_seq at WIDTH=4, NUM=4 (OUT_W=7).
module tb_cc_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_n = '0;
    logic [3:0] opt = '0;
    logic       in_ready;
    logic       out_valid;
    logic [6:0] out_n;

    int assertions = 0;
    int failures   = 0;
    int cyc        = 0;

    typedef struct {
        string      name;
        logic [3:0] a, b, c, d;
        logic [3:0] o;
        int         gap;
        logic [6:0] exp;
    } txn_t;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cc_seq #(.WIDTH(4), .NUM(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_n      (in_n),
        .opt       (opt),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_n     (out_n)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Later operands carry inverted options so an unlatched opt shows up as a wrong result.
    task automatic drive_op(input logic [3:0] v, input logic [3:0] o, input int gap);
        in_valid = 1'b1;
        in_n     = v;
        opt      = o;
        step();
        in_valid = 1'b0;
        in_n     = '0;
        repeat (gap) step();
    endtask

    task automatic wait_out(output logic [6:0] val, output int edge_seen, output bit ok);
        int n;
        ok = 1'b0;
        val = '0;
        edge_seen = -1;
        n = 0;
        while (!ok && n < 40) begin
            if (out_valid === 1'b1) begin
                ok = 1'b1;
                val = out_n;
                edge_seen = cyc;
            end else begin
                step();
                n++;
            end
        end
    endtask

    task automatic run_txn(input txn_t t, output logic [6:0] val, output int lat,
                           output int edge_seen, output bit ok);
        int last;
        step();
        drive_op(t.a, t.o, t.gap);
        drive_op(t.b, ~t.o, t.gap);
        drive_op(t.c, ~t.o, t.gap);
        drive_op(t.d, ~t.o, 0);
        last = cyc;
        wait_out(val, edge_seen, ok);
        lat = edge_seen - last;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        assertions++;
        if (out_valid !== 1'b0 || out_n !== 7'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: out_valid=%b out_n=%0d in_ready=%b, want 0 0 1",
                     out_valid, out_n, in_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic run_table(input txn_t v [$]);
        logic [6:0] val;
        int lat, e;
        bit ok;
        foreach (v[i]) begin
            run_txn(v[i], val, lat, e, ok);
            assertions++;
            if (!ok) begin
                failures++;
                $display("FAIL %s_timeout: no out_valid within 40 cycles", v[i].name);
            end
            assertions++;
            if (val !== v[i].exp) begin
                failures++;
                $display("FAIL %s: out_n=0x%0h, want 0x%0h", v[i].name, val, v[i].exp);
            end
            assertions++;
            if (lat !== 5) begin
                failures++;
                $display("FAIL %s_latency: out_valid %0d edges after last operand, want 5",
                         v[i].name, lat);
            end
        end
    endtask

    task automatic test_unsigned_modes();
        txn_t v [$];
        v.push_back('{"u_sum",       4'd3, 4'd9, 4'd1, 4'd6, 4'b0000, 0, 7'd19});
        v.push_back('{"u_range",     4'd3, 4'd9, 4'd1, 4'd6, 4'b0100, 0, 7'd8});
        v.push_back('{"u_half_asc",  4'd3, 4'd9, 4'd1, 4'd6, 4'b1000, 0, 7'd4});
        v.push_back('{"u_half_desc", 4'd3, 4'd9, 4'd1, 4'd6, 4'b1010, 0, 7'd15});
        v.push_back('{"u_med_asc",   4'd3, 4'd9, 4'd1, 4'd6, 4'b1100, 0, 7'd6});
        v.push_back('{"u_med_desc",  4'd3, 4'd9, 4'd1, 4'd6, 4'b1110, 0, 7'd3});
        v.push_back('{"u_sum_max",   4'hF, 4'hF, 4'hF, 4'hF, 4'b0000, 0, 7'd60});
        run_table(v);
    endtask

    task automatic test_signed_modes();
        txn_t v [$];
        v.push_back('{"s_sum",        4'hF, 4'h7, 4'h8, 4'h2, 4'b0001, 0, 7'd0});
        v.push_back('{"s_range",      4'hF, 4'h7, 4'h8, 4'h2, 4'b0101, 0, 7'd15});
        v.push_back('{"s_range_desc", 4'hF, 4'h7, 4'h8, 4'h2, 4'b0111, 0, 7'd15});
        v.push_back('{"s_med_asc",    4'hF, 4'h7, 4'h8, 4'h2, 4'b1101, 0, 7'd2});
        v.push_back('{"s_med_desc",   4'hF, 4'h7, 4'h8, 4'h2, 4'b1111, 0, 7'h7F});
        v.push_back('{"s_half_asc",   4'hF, 4'h7, 4'h8, 4'h2, 4'b1001, 0, 7'h77});
        v.push_back('{"s_sum_neg",    4'hF, 4'hF, 4'hF, 4'hF, 4'b0001, 0, 7'h7C});
        run_table(v);
    endtask

    task automatic test_gaps();
        txn_t v [$];
        v.push_back('{"gap_u_sum",      4'd3, 4'd9, 4'd1, 4'd6, 4'b0000, 2, 7'd19});
        v.push_back('{"gap_u_half_dsc", 4'd3, 4'd9, 4'd1, 4'd6, 4'b1010, 2, 7'd15});
        v.push_back('{"gap_s_med_desc", 4'hF, 4'h7, 4'h8, 4'h2, 4'b1111, 2, 7'h7F});
        run_table(v);
    endtask

    task automatic test_busy();
        logic [6:0] val;
        int last, e;
        bit ok;
        step();
        drive_op(4'd3, 4'b0000, 0);
        drive_op(4'd9, 4'b0000, 0);
        drive_op(4'd1, 4'b0000, 0);
        drive_op(4'd6, 4'b0000, 0);
        last = cyc;
        assertions++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL busy_ready: in_ready=%b after last operand, want 0", in_ready);
        end
        in_valid = 1'b1;
        in_n     = 4'hF;
        repeat (3) step();
        in_valid = 1'b0;
        in_n     = '0;
        wait_out(val, e, ok);
        assertions++;
        if (!ok || val !== 7'd19) begin
            failures++;
            $display("FAIL busy_result: out_n=%0d ok=%b, want 19", val, ok);
        end
        assertions++;
        if (e - last !== 5) begin
            failures++;
            $display("FAIL busy_latency: %0d edges, want 5", e - last);
        end
    endtask

    task automatic test_reset_mid();
        txn_t t;
        logic [6:0] val;
        int lat, e;
        bit ok, seen;
        step();
        drive_op(4'd5, 4'b0000, 0);
        drive_op(4'd5, 4'b1111, 0);
        rst_n = 1'b0;
        step();
        assertions++;
        if (out_valid !== 1'b0 || out_n !== 7'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_state: out_valid=%b out_n=%0d in_ready=%b, want 0 0 1",
                     out_valid, out_n, in_ready);
        end
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            step();
            if (out_valid === 1'b1) seen = 1'b1;
        end
        assertions++;
        if (seen) begin
            failures++;
            $display("FAIL mid_reset_discard: out_valid=1 seen after reset, want 0");
        end
        t = '{"after_reset", 4'd1, 4'd1, 4'd1, 4'd1, 4'b0000, 0, 7'd4};
        run_txn(t, val, lat, e, ok);
        assertions++;
        if (!ok || val !== 7'd4) begin
            failures++;
            $display("FAIL after_reset_sum: out_n=%0d ok=%b, want 4", val, ok);
        end
    endtask

    task automatic test_back_to_back();
        txn_t t1, t2;
        logic [6:0] v1, v2;
        int l1, l2, e1, e2;
        bit ok1, ok2;
        t1 = '{"b2b_first",  4'd3, 4'd9, 4'd1, 4'd6, 4'b0000, 0, 7'd19};
        t2 = '{"b2b_second", 4'hF, 4'h7, 4'h8, 4'h2, 4'b0101, 0, 7'd15};
        run_txn(t1, v1, l1, e1, ok1);
        run_txn(t2, v2, l2, e2, ok2);
        assertions++;
        if (!ok1 || v1 !== 7'd19) begin
            failures++;
            $display("FAIL b2b_first: out_n=%0d ok=%b, want 19", v1, ok1);
        end
        assertions++;
        if (!ok2 || v2 !== 7'd15) begin
            failures++;
            $display("FAIL b2b_second: out_n=%0d ok=%b, want 15", v2, ok2);
        end
        assertions++;
        if (e2 - e1 !== 10) begin
            failures++;
            $display("FAIL b2b_period: out_valid pulses %0d cycles apart, want 10", e2 - e1);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_modes();
        test_signed_modes();
        test_gaps();
        test_busy();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
